// File: rtl/decode.sv
// ---------------------------------------------------------------------------
// decode -- RV32I instruction decode stage.
//
// Sits directly behind fetch. Accepts one (pc, insn) pair per valid/ready
// handshake, then extracts the register indices, function fields and the
// sign-extended immediate. The result is held in a one-entry output register.
// That register stalls under back-pressure and clears on flush.
//
// Optional feature macro: DECODE_ILLEGAL_EN
//   defined     : the opcode is checked against the RV32I base set, and
//                 illegal_o is registered together with the instruction.
//   not defined : the check logic is absent and illegal_o is tied to 0.
//                 Unknown opcodes still produce imm_o = 0.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   insn_valid_i/ready_o handshake with fetch
//   pc_i, insn_i         offered PC and instruction word
//   flush_i              discard held and offered instruction (redirect)
//   out_valid_o/ready_i  handshake with register-read/execute
//   pc_o, insn_o         registered PC and raw instruction
//   opcode_o, rd_o, rs1_o, rs2_o, funct3_o, funct7_o
//                        raw instruction slices
//   imm_o                sign-extended immediate (format chosen by opcode)
//   illegal_o            opcode is not RV32I
// ---------------------------------------------------------------------------
module decode #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              insn_valid_i,
  output logic              insn_ready_o,
  input  logic [AWIDTH-1:0] pc_i,
  input  logic [DWIDTH-1:0] insn_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o,
  output logic [6:0]        opcode_o,
  output logic [4:0]        rd_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [2:0]        funct3_o,
  output logic [6:0]        funct7_o,
  output logic [DWIDTH-1:0] imm_o,
  output logic              illegal_o
);

  localparam logic [6:0] OP_LOAD     = 7'h03;
  localparam logic [6:0] OP_MISC_MEM = 7'h0F;
  localparam logic [6:0] OP_IMM      = 7'h13;
  localparam logic [6:0] OP_AUIPC    = 7'h17;
  localparam logic [6:0] OP_STORE    = 7'h23;
  localparam logic [6:0] OP_REG      = 7'h33;
  localparam logic [6:0] OP_LUI      = 7'h37;
  localparam logic [6:0] OP_BRANCH   = 7'h63;
  localparam logic [6:0] OP_JALR     = 7'h67;
  localparam logic [6:0] OP_JAL      = 7'h6F;
  localparam logic [6:0] OP_SYSTEM   = 7'h73;

  // Immediate assembly by instruction format. R-type, FENCE and unknown
  // opcodes carry no immediate.
  function automatic logic [DWIDTH-1:0] imm_gen(input logic [DWIDTH-1:0] insn);
    case (insn[6:0])
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
        imm_gen = {{(DWIDTH-12){insn[31]}}, insn[31:20]};
      OP_STORE:
        imm_gen = {{(DWIDTH-12){insn[31]}}, insn[31:25], insn[11:7]};
      OP_BRANCH:
        imm_gen = {{(DWIDTH-13){insn[31]}}, insn[31], insn[7], insn[30:25],
                   insn[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm_gen = {insn[DWIDTH-1:12], 12'b0};
      OP_JAL:
        imm_gen = {{(DWIDTH-21){insn[31]}}, insn[31], insn[19:12], insn[20],
                   insn[30:21], 1'b0};
      default:
        imm_gen = '0;
    endcase
  endfunction

  logic              valid_q, valid_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [DWIDTH-1:0] insn_q, insn_d;
  logic [DWIDTH-1:0] imm_q, imm_d;
  logic              capture;

  // The output register is free when it is empty, when its contents leave
  // this cycle, or when a flush discards them.
  assign insn_ready_o = flush_i | ~valid_q | out_ready_i;
  assign capture      = insn_valid_i & insn_ready_o & ~flush_i;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    insn_d  = insn_q;
    imm_d   = imm_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      insn_d  = insn_i;
      imm_d   = imm_gen(insn_i);
    end else if (out_ready_i) begin
      // Consumed with nothing new behind it; the field registers keep
      // their last value.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      insn_q  <= '0;
      imm_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      insn_q  <= insn_d;
      imm_q   <= imm_d;
    end
  end

`ifdef DECODE_ILLEGAL_EN
  function automatic logic is_illegal(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_MISC_MEM, OP_IMM, OP_AUIPC, OP_STORE, OP_REG, OP_LUI,
      OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM:
        is_illegal = 1'b0;
      default:
        is_illegal = 1'b1;
    endcase
  endfunction

  logic illegal_q, illegal_d;

  always_comb begin
    illegal_d = illegal_q;
    if (capture) begin
      illegal_d = is_illegal(insn_i[6:0]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign illegal_o = illegal_q;
`else
  assign illegal_o = 1'b0;
`endif

  // Field outputs are raw slices of the registered instruction word, so
  // they load, hold and reset together with insn_q.
  assign out_valid_o = valid_q;
  assign pc_o        = pc_q;
  assign insn_o      = insn_q;
  assign imm_o       = imm_q;
  assign opcode_o    = insn_q[6:0];
  assign rd_o        = insn_q[11:7];
  assign rs1_o       = insn_q[19:15];
  assign rs2_o       = insn_q[24:20];
  assign funct3_o    = insn_q[14:12];
  assign funct7_o    = insn_q[31:25];

endmodule

// File: tb/tb_decode.sv
module tb_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        insn_valid_i;
  logic        insn_ready_o;
  logic [31:0] pc_i;
  logic [31:0] insn_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] pc_o;
  logic [31:0] insn_o;
  logic [6:0]  opcode_o;
  logic [4:0]  rd_o, rs1_o, rs2_o;
  logic [2:0]  funct3_o;
  logic [6:0]  funct7_o;
  logic [31:0] imm_o;
  logic        illegal_o;

  decode #(.AWIDTH(32), .DWIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .insn_valid_i(insn_valid_i), .insn_ready_o(insn_ready_o),
    .pc_i(pc_i), .insn_i(insn_i), .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .pc_o(pc_o), .insn_o(insn_o), .opcode_o(opcode_o),
    .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
    .funct3_o(funct3_o), .funct7_o(funct7_o),
    .imm_o(imm_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

`ifdef DECODE_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  logic [6:0] legal_ops [11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                                 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};

  // Reference model: the held instruction as seen by downstream.
  bit          m_v;
  logic [31:0] m_pc, m_insn, m_imm;
  bit          m_ill;
  logic [31:0] accepted_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit ref_legal(input logic [31:0] insn);
    ref_legal = 1'b0;
    foreach (legal_ops[i]) if (legal_ops[i] == insn[6:0]) ref_legal = 1'b1;
  endfunction

  // Immediate value built arithmetically from the ISA field layout.
  function automatic logic [31:0] ref_imm(input logic [31:0] insn);
    int v;
    int sgn;
    sgn = insn[31] ? 1 : 0;
    case (insn[6:0])
      7'h03, 7'h13, 7'h67, 7'h73: v = -2048 * sgn + int'(insn[30:20]);
      7'h23: v = -2048 * sgn + int'(insn[30:25]) * 32 + int'(insn[11:7]);
      7'h63: v = -4096 * sgn + int'(insn[7]) * 2048 + int'(insn[30:25]) * 32
                 + int'(insn[11:8]) * 2;
      7'h37, 7'h17: v = int'(insn & 32'hFFFF_F000);
      7'h6F: v = -1048576 * sgn + int'(insn[19:12]) * 4096 + int'(insn[20]) * 2048
                 + int'(insn[30:21]) * 2;
      default: v = 0;
    endcase
    ref_imm = 32'(v);
  endfunction

  task automatic model_reset();
    m_v = 0; m_pc = '0; m_insn = '0; m_imm = '0; m_ill = 0;
    accepted_q.delete();
  endtask

  task automatic compare_all();
    chk("out_valid", out_valid_o, m_v);
    chk("pc_o", pc_o, m_pc);
    chk("insn_o", insn_o, m_insn);
    chk("opcode", opcode_o, m_insn[6:0]);
    chk("rd", rd_o, m_insn[11:7]);
    chk("rs1", rs1_o, m_insn[19:15]);
    chk("rs2", rs2_o, m_insn[24:20]);
    chk("funct3", funct3_o, m_insn[14:12]);
    chk("funct7", funct7_o, m_insn[31:25]);
    chk("imm", imm_o, m_imm);
    chk("illegal", illegal_o, m_ill);
  endtask

  // Drive one cycle starting just after a rising edge, check ready before
  // the edge, advance the model at the edge, then check all outputs.
  task automatic drive_cycle(input bit iv, input logic [31:0] pc, input logic [31:0] insn,
                             input bit fl, input bit ordy);
    bit rdy, cap;
    insn_valid_i = iv; pc_i = pc; insn_i = insn; flush_i = fl; out_ready_i = ordy;
    #1;
    rdy = fl || !m_v || ordy;
    cap = iv && rdy && !fl;
    chk("insn_ready", insn_ready_o, rdy);
    // Order check: whatever leaves downstream must be the oldest accepted.
    if (out_valid_o && ordy && !fl) begin
      if (accepted_q.size() == 0) chk("consume_unexpected", 1, 0);
      else chk("consume_order_pc", pc_o, accepted_q.pop_front());
    end
    @(posedge clk);
    if (fl) begin
      m_v = 0;
      accepted_q.delete();
    end else if (cap) begin
      m_v = 1; m_pc = pc; m_insn = insn; m_imm = ref_imm(insn);
      m_ill = ILL_EN && !ref_legal(insn);
      accepted_q.push_back(pc);
    end else if (m_v && ordy) begin
      m_v = 0;
    end
    #1;
    compare_all();
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{32'h0100_0000, 32'h0050_0093, 7'h13, 5'd1,  5'd0, 5'd5, 3'd0, 7'h00, 32'h0000_0005};
    vecs[1] = '{32'h0100_0004, 32'hFE20_AE23, 7'h23, 5'h1C, 5'd1, 5'd2, 3'd2, 7'h7F, 32'hFFFF_FFFC};
    vecs[2] = '{32'h0100_0008, 32'h1234_50B7, 7'h37, 5'd1,  5'd8, 5'd3, 3'd5, 7'h09, 32'h1234_5000};
    vecs[3] = '{32'h0100_000C, 32'hFE00_0EE3, 7'h63, 5'h1D, 5'd0, 5'd0, 3'd0, 7'h7F, 32'hFFFF_FFFC};
    vecs[4] = '{32'h0100_0010, 32'h0000_0000, 7'h00, 5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0000};

    rst = 1'b1; insn_valid_i = 0; pc_i = '0; insn_i = '0; flush_i = 0; out_ready_i = 0;
    model_reset();
    #22 rst = 1'b0;
    #1;
    // Reset state, no input offered.
    chk("reset_ready", insn_ready_o, 1);
    compare_all();
    @(posedge clk); #1;

    // Directed table, downstream always ready.
    foreach (vecs[i]) begin
      drive_cycle(1, vecs[i].pc, vecs[i].insn, 0, 1);
      chk("tbl_valid", out_valid_o, 1);
      chk("tbl_pc", pc_o, vecs[i].pc);
      chk("tbl_opcode", opcode_o, vecs[i].op);
      chk("tbl_rd", rd_o, vecs[i].rd);
      chk("tbl_rs1", rs1_o, vecs[i].rs1);
      chk("tbl_rs2", rs2_o, vecs[i].rs2);
      chk("tbl_funct3", funct3_o, vecs[i].f3);
      chk("tbl_funct7", funct7_o, vecs[i].f7);
      chk("tbl_imm", imm_o, vecs[i].imm);
    end
    // Last table entry was the all-zero word.
    chk("zero_insn_illegal", illegal_o, ILL_EN);
    drive_cycle(0, '0, '0, 0, 1);
    chk("drain_valid", out_valid_o, 0);

    // Back-pressure: two back-to-back offers with downstream stalled.
    drive_cycle(1, 32'h0000_0100, 32'h0050_0093, 0, 0);
    drive_cycle(1, 32'h0000_0104, 32'hFE20_AE23, 0, 0);
    chk("stall_pc_frozen", pc_o, 32'h0000_0100);
    drive_cycle(1, 32'h0000_0104, 32'hFE20_AE23, 0, 0);
    chk("stall_ready_low", insn_ready_o, 0);
    drive_cycle(1, 32'h0000_0104, 32'hFE20_AE23, 0, 1);
    chk("stall_second_pc", pc_o, 32'h0000_0104);
    chk("stall_second_imm", imm_o, 32'hFFFF_FFFC);
    drive_cycle(0, '0, '0, 0, 1);
    chk("stall_drained", out_valid_o, 0);

    // Flush while holding and offering.
    drive_cycle(1, 32'h0000_0200, 32'h0000_0013, 0, 0);
    drive_cycle(1, 32'h0100_0000, 32'h0050_0093, 1, 0);
    chk("flush_valid", out_valid_o, 0);
    drive_cycle(1, 32'h0100_0000, 32'h0050_0093, 0, 0);
    chk("post_flush_valid", out_valid_o, 1);
    chk("post_flush_imm", imm_o, 32'h5);

    // Asynchronous reset between edges with an instruction held.
    insn_valid_i = 0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst_valid", out_valid_o, 0);
    chk("async_rst_pc", pc_o, 0);
    chk("async_rst_imm", imm_o, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] ins;
      ins = $urandom;
      if ($urandom_range(0, 3) != 0) ins[6:0] = legal_ops[$urandom_range(0, 10)];
      drive_cycle($urandom_range(0, 9) < 6, $urandom, ins,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
